invsqrt_arbiter: RTL
====================

Name: invsqrt_arbiter

Overview:
- Shares one invsqrt core among N_REQ requesters using round-robin arbitration.
- Latches the granted operand and drives the core's start/operand inputs.
- Waits for the core's ready, returns the tagged result on a valid/ready response port.
- Screens illegal operands without using the core, and times out a hung core.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_W, 2, requester-id width, must equal clog2(N_REQ)
TIMEOUT, 64, maximum WAIT-state cycles before a forced timeout response

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester request valid
req_data  input  32*N_REQ  packed IEEE-754 single operands; requester i at [32i+31:32i]
req_ready  output  N_REQ  one-hot grant/accept pulse
core_start  output  1  one-cycle start pulse to invsqrt core
core_operand  output  32  operand to core; held stable for the whole operation
core_result  input  32  core float result
core_ready  input  1  core done level; cleared by core the cycle after start
res_valid  output  1  response valid
res_data  output  32  result
res_id  output  ID_W  requester index of the response
res_err  output  1  operand was illegal; res_data is 0x7FFFFFFF
res_timeout  output  1  core timed out; res_data is 0x7FFFFFFF
res_ready  input  1  response consumer ready
busy  output  1  state is not IDLE
done_cnt  output  16  count of completed responses, wraps at 0xFFFF

Behaviour:
- Reset values:
  - state=IDLE, last-grant pointer=N_REQ-1, so requester 0 has first priority.
  - req_ready=0, core_start=0, core_operand=0.
  - res_valid=0, res_data=0, res_id=0, res_err=0, res_timeout=0, busy=0, done_cnt=0.
  - Timeout counter=0.
- Reset mid-operation aborts everything: no response is emitted, and any in-flight core result is discarded.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant the first set bit searching upward from pointer+1 (mod N_REQ).
  - Grant is combinational: req_ready[g]=1 for that cycle only, and the handshake completes in that cycle.
  - On the clock edge: latch req_data[g] into core_operand, latch g into res_id, pointer<=g.
  - If the operand is illegal (==0x00000000, exponent==0xFF, or sign==1): res_data<=0x7FFFFFFF, res_err<=1, go to RESP. The core is not started.
  - Otherwise go to ISSUE.
  - Negative zero (0x80000000) is illegal because its sign bit is set.
- ISSUE:
  - core_start=1 for exactly this cycle.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - Sample core_ready only in this state; it is never sampled in ISSUE.
  - If core_ready=1: res_data<=core_result, res_err<=0, res_timeout<=0, go to RESP.
  - Else if the counter == TIMEOUT-1: res_data<=0x7FFFFFFF, res_timeout<=1, go to RESP.
  - Else increment the counter.
  - core_operand is held constant.
- RESP:
  - res_valid=1. res_data, res_id, res_err and res_timeout stay stable while res_ready=0.
  - When res_valid&&res_ready: done_cnt increments (wrapping) and the state goes to IDLE.
  - res_valid falls the next cycle.
  - No grants are issued outside IDLE. The earliest next grant is the cycle after the handshake.
- Latency (legal operand, core latency L cycles from start to ready):
  - grant at T0, start at T1, res_valid at T1+L+1.
  - Illegal operand: res_valid at T1.
- Simultaneous events:
  - core_ready and the timeout coinciding: core_ready wins.
  - A requester dropping req_valid before it is granted is not served. There is no queuing.

Test Plan:
- Single request, requester 2, operand 0x40800000 (4.0), core model latency 10 -> core_start at T1; res_valid at T12; res_id=2; res_err=0; res_data within 0.2% of 0.5 (0x3F000000).
- All four req_valid held high, legal operands -> grants in order 0,1,2,3,0; each req_ready exactly one cycle; done_cnt=5.
- Requester 1 operand 0x00000000, then 0xBF800000 (-1.0), then 0x7F800000 (+inf) -> each response has res_err=1 and res_data=0x7FFFFFFF one cycle after grant; core_start never asserted.
- res_ready held low 5 cycles during RESP with requester 3 waiting -> res_valid, res_data and res_id stable; req_ready stays 0; grant to 3 occurs the cycle after the handshake.
- TIMEOUT=16, core model never asserts ready -> res_timeout=1 and res_data=0x7FFFFFFF, with res_valid 17 cycles after core_start; the next request is served normally.
- rst asserted in WAIT -> next cycle all outputs at reset values; a late core_ready produces no response; a request after reset is granted to requester 0 first.

Source files
------------

// File: rtl/invsqrt_arbiter.sv
// Round-robin front end that shares one inverse-square-root core among N_REQ requesters.
// Illegal operands are rejected without using the core. A core that never finishes is
// cut off after TIMEOUT wait cycles.
module invsqrt_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 core_start,
  output logic [31:0]          core_operand,
  input  logic [31:0]          core_result,
  input  logic                 core_ready,
  output logic                 res_valid,
  output logic [31:0]          res_data,
  output logic [ID_W-1:0]      res_id,
  output logic                 res_err,
  output logic                 res_timeout,
  input  logic                 res_ready,
  output logic                 busy,
  output logic [15:0]          done_cnt
);

  localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CW      = ID_W + 1;
  localparam logic [31:0] BAD_RES = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_found;
  logic [31:0]       gnt_data;
  logic              gnt_illegal;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [CW-1:0]     cand;

  // Round-robin search: first valid requester strictly after the last grant, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Select the granted requester's operand.
  always_comb begin
    gnt_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == gnt_idx) gnt_data = req_data[32*k +: 32];
    end
  end

  // Zero, Inf/NaN and any negative value (including -0) have no real inverse square root.
  assign gnt_illegal = (gnt_data == 32'h0) || (gnt_data[30:23] == 8'hFF) || gnt_data[31];

  // Grant is combinational so the request handshake completes in the grant cycle.
  always_comb begin
    req_ready = '0;
    if (state == StIdle && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign busy = (state != StIdle);

  // Main control FSM with registered core and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      ptr          <= ID_W'(N_REQ - 1);
      core_start   <= 1'b0;
      core_operand <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_id       <= '0;
      res_err      <= 1'b0;
      res_timeout  <= 1'b0;
      done_cnt     <= '0;
      tmo_cnt      <= '0;
    end else begin
      core_start <= 1'b0;
      unique case (state)
        StIdle: begin
          if (gnt_found) begin
            core_operand <= gnt_data;
            res_id       <= gnt_idx;
            ptr          <= gnt_idx;
            res_timeout  <= 1'b0;
            if (gnt_illegal) begin
              res_data  <= BAD_RES;
              res_err   <= 1'b1;
              res_valid <= 1'b1;
              state     <= StResp;
            end else begin
              res_err    <= 1'b0;
              core_start <= 1'b1;
              state      <= StIssue;
            end
          end
        end
        StIssue: begin
          // core_ready may still be high from the previous op here, so it is not sampled.
          tmo_cnt <= '0;
          state   <= StWait;
        end
        StWait: begin
          if (core_ready) begin
            res_data    <= core_result;
            res_err     <= 1'b0;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state       <= StResp;
          end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
            res_data    <= BAD_RES;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= StResp;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        StResp: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            done_cnt  <= done_cnt + 16'd1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
